// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps one imem request in flight
// and registers returned instructions into the fetch/decode pipeline register.
module fetch_stage #(
  parameter int                 WIDTH    = 32,
  parameter logic [WIDTH-1:0]   RESET_PC = 32'h0000_0000,
  parameter logic [WIDTH-1:0]   NOP      = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] pc_f,
  output logic [WIDTH-1:0] ins_f,
  input  logic [WIDTH-1:0] pc_next_i,
  input  logic             branch_predicted_i,
  input  logic             flush_i,
  input  logic             stall_i,
  output logic             valid_d,
  output logic [WIDTH-1:0] instr_d,
  output logic [WIDTH-1:0] pc_d,
  output logic [WIDTH-1:0] pcplus4_d,
  output logic             branch_predicted_d
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [WIDTH-1:0] hold_reg, hold_next;
  logic             accept;
  logic             load_d;
  logic [WIDTH-1:0] load_ins;

  logic             valid_d_next;
  logic [WIDTH-1:0] instr_d_next, pc_d_next, pcplus4_d_next;
  logic             branch_predicted_d_next;

  assign accept    = !valid_d || !stall_i;
  assign imem_addr = pc_reg;
  assign pc_f      = pc_reg;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    hold_next  = hold_reg;
    imem_req   = 1'b0;
    ins_f      = NOP;
    load_d     = 1'b0;
    load_ins   = hold_reg;

    case (state_reg)
      IDLE: state_next = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_ready) state_next = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          ins_f    = imem_rdata;
          load_ins = imem_rdata;
          if (accept) begin
            load_d     = 1'b1;
            state_next = REQ;
          end else begin
            hold_next  = imem_rdata;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        ins_f = hold_reg;
        if (accept) begin
          load_d     = 1'b1;
          state_next = REQ;
        end
      end
      DROP: begin
        if (imem_rvalid) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase

    // The bpu closes the fetch loop combinationally: its pc_next is taken at the load edge.
    if (load_d) pc_next = pc_next_i;

    // Flush wins over everything; an accepted-but-unanswered request must be drained in DROP.
    if (flush_i) begin
      load_d    = 1'b0;
      pc_next   = pc_next_i;
      hold_next = hold_reg;
      case (state_reg)
        REQ:     state_next = imem_ready  ? DROP : REQ;
        WAIT:    state_next = imem_rvalid ? REQ  : DROP;
        default: state_next = REQ;
      endcase
    end

    valid_d_next            = valid_d;
    instr_d_next            = instr_d;
    pc_d_next               = pc_d;
    pcplus4_d_next          = pcplus4_d;
    branch_predicted_d_next = branch_predicted_d;
    if (flush_i) begin
      valid_d_next = 1'b0;
    end else if (load_d) begin
      valid_d_next            = 1'b1;
      instr_d_next            = load_ins;
      pc_d_next               = pc_reg;
      pcplus4_d_next          = pc_reg + WIDTH'(4);
      branch_predicted_d_next = branch_predicted_i;
    end else if (accept) begin
      valid_d_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg          <= IDLE;
      pc_reg             <= RESET_PC;
      hold_reg           <= NOP;
      valid_d            <= 1'b0;
      instr_d            <= NOP;
      pc_d               <= '0;
      pcplus4_d          <= '0;
      branch_predicted_d <= 1'b0;
    end else begin
      state_reg          <= state_next;
      pc_reg             <= pc_next;
      hold_reg           <= hold_next;
      valid_d            <= valid_d_next;
      instr_d            <= instr_d_next;
      pc_d               <= pc_d_next;
      pcplus4_d          <= pcplus4_d_next;
      branch_predicted_d <= branch_predicted_d_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory and bpu models drive the DUT, a program-order
// reference stream feeds a scoreboard that a separate monitor drains.
module tb_fetch_stage;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] JAL      = 32'h0080_006F;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc_f, ins_f;
  logic [31:0] pc_next_i;
  logic        branch_predicted_i;
  logic        flush_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        valid_d;
  logic [31:0] instr_d, pc_d, pcplus4_d;
  logic        branch_predicted_d;
  logic [31:0] flush_target = 32'h0;

  fetch_stage #(.WIDTH(32), .RESET_PC(RESET_PC), .NOP(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_f(pc_f), .ins_f(ins_f), .pc_next_i(pc_next_i),
    .branch_predicted_i(branch_predicted_i), .flush_i(flush_i), .stall_i(stall_i),
    .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d),
    .branch_predicted_d(branch_predicted_d)
  );

  always #5 clk = ~clk;

  // Instruction image: low addresses hold NOPs, every 8th word is jal +8.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'h10) return NOP;
    if (a[4:2] == 3'd4) return JAL;
    return {a[26:2], 7'h13};
  endfunction

  // bpu: predicts jal taken (+8), otherwise sequential; supplies the target on flush.
  always_comb begin
    pc_next_i          = pc_f + 32'd4;
    branch_predicted_i = 1'b0;
    if (flush_i) begin
      pc_next_i = flush_target;
    end else if (ins_f == JAL) begin
      pc_next_i          = pc_f + 32'd8;
      branch_predicted_i = 1'b1;
    end
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic        bp;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          loads = 0;

  bit          mem_pending = 0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_delay = 0;
  int          lat_lo = 0, lat_hi = 0, ready_pct = 100;
  bit          inject_rvalid = 0;
  int          last_rvalid_cyc = 0;
  logic [31:0] req_addr_log[$];
  int          req_cyc_log[$];

  bit          pending_restart = 0;
  logic [31:0] restart_pc = 32'h0;
  bit          stall_arm = 0;
  logic [31:0] stall_addr = 32'h0;
  int          stall_cnt = 0, stall_idx = 0;

  logic [31:0] exp_addrs [7] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h18, 32'h1C};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: instructions reach D in program order, following predicted jal targets.
  function automatic void push_stream(input logic [31:0] start, input int n);
    logic [31:0] pc = start;
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.instr = mem_word(pc);
      e.pc    = pc;
      e.pcp4  = pc + 32'd4;
      e.bp    = (e.instr == JAL);
      sb.push_back(e);
      pc = e.bp ? pc + 32'd8 : pc + 32'd4;
    end
  endfunction

  // Monitor: samples 1 time unit after each rising edge and judges that edge.
  initial begin : monitor
    logic        pv, pb;
    logic [31:0] pi, pp, pp4;
    exp_t        e;
    pv = 0; pb = 0; pi = 0; pp = 0; pp4 = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        check("rst_valid_d", {31'b0, valid_d}, 32'd0);
        check("rst_instr_d", instr_d, NOP);
        check("rst_pc_d", pc_d, 32'd0);
        check("rst_pcplus4_d", pcplus4_d, 32'd0);
        check("rst_bp_d", {31'b0, branch_predicted_d}, 32'd0);
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_pc_f", pc_f, RESET_PC);
      end else if (flush_i) begin
        check("flush_clears_valid", {31'b0, valid_d}, 32'd0);
      end else if (pv && stall_i) begin
        check("stall_valid_hold", {31'b0, valid_d}, 32'd1);
        check("stall_instr_hold", instr_d, pi);
        check("stall_pc_hold", pc_d, pp);
        check("stall_pcp4_hold", pcplus4_d, pp4);
        check("stall_bp_hold", {31'b0, branch_predicted_d}, {31'b0, pb});
      end else if (valid_d) begin
        loads++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_load: got pc_d %h expected no load (cycle %0d)", pc_d, cyc);
        end else begin
          e = sb.pop_front();
          check("d_instr", instr_d, e.instr);
          check("d_pc", pc_d, e.pc);
          check("d_pcplus4", pcplus4_d, e.pcp4);
          check("d_bp", {31'b0, branch_predicted_d}, {31'b0, e.bp});
        end
      end
      pv = valid_d; pi = instr_d; pp = pc_d; pp4 = pcplus4_d; pb = branch_predicted_d;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic neg();
    @(negedge clk);
    cyc++;
    if (pending_restart) begin
      sb.delete();
      push_stream(restart_pc, 1100);
      pending_restart = 0;
    end
  endtask

  task automatic drive_mem();
    bit was_pending = mem_pending;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (imem_req) check("one_outstanding", {31'b0, was_pending}, 32'd0);
    if (mem_pending) begin
      if (mem_delay == 0) begin
        imem_rvalid     = 1'b1;
        imem_rdata      = mem_word(mem_addr);
        mem_pending     = 0;
        last_rvalid_cyc = cyc;
      end else begin
        mem_delay--;
      end
    end
    if (inject_rvalid) begin
      imem_rvalid   = 1'b1;
      inject_rvalid = 0;
    end
    imem_ready = !was_pending && ($urandom_range(1, 100) <= ready_pct);
    if (imem_req && imem_ready) begin
      mem_pending = 1;
      mem_addr    = imem_addr;
      mem_delay   = $urandom_range(lat_lo, lat_hi);
      req_addr_log.push_back(imem_addr);
      req_cyc_log.push_back(cyc);
    end
  endtask

  task automatic apply(input bit st, input bit fl, input logic [31:0] tgt);
    if (stall_arm && imem_req && imem_addr == stall_addr) begin
      stall_arm = 0;
      stall_cnt = 3;
    end
    if (stall_cnt > 0) begin
      stall_cnt--;
      stall_idx++;
    end else begin
      stall_idx = 0;
    end
    stall_i      = st || (stall_idx != 0);
    flush_i      = fl;
    flush_target = tgt;
    if (fl) begin
      pending_restart = 1;
      restart_pc      = tgt;
    end
    drive_mem();
  endtask

  task automatic step(input bit st, input bit fl, input logic [31:0] tgt);
    neg();
    apply(st, fl, tgt);
  endtask

  task automatic do_reset(input int n, input bit inject);
    for (int i = 0; i < n; i++) begin
      neg();
      rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
      imem_ready = 1'b0; imem_rvalid = 1'b0;
      mem_pending = 0; stall_cnt = 0; stall_idx = 0; stall_arm = 0;
      pending_restart = 0;
      sb.delete();
    end
    neg();
    rst = 1'b1;
    push_stream(RESET_PC, 1100);
    req_addr_log.delete();
    req_cyc_log.delete();
    inject_rvalid = inject;
    apply(0, 0, 32'h0);
    check("idle_no_req", {31'b0, imem_req}, 32'd0);
    check("idle_pc_f", pc_f, RESET_PC);
  endtask

  initial begin : stimulus
    int guard, first_d_cyc, n0, l0;
    bit saw_hold, found;
    logic [31:0] tgt;

    // Zero-wait memory, 3-cycle stall at PC 8, predicted jal at 0x10.
    lat_lo = 0; lat_hi = 0; ready_pct = 100;
    do_reset(3, 0);
    stall_arm = 1; stall_addr = 32'h8;
    step(0, 0, 32'h0);
    check("first_req", {31'b0, imem_req}, 32'd1);
    check("first_addr", imem_addr, RESET_PC);
    first_d_cyc = -1; guard = 0; saw_hold = 0;
    while (req_addr_log.size() < 7 && guard < 60) begin
      step(0, 0, 32'h0);
      guard++;
      if (valid_d && pc_d == 32'h0 && first_d_cyc < 0) first_d_cyc = cyc;
      if (stall_idx >= 2) begin
        saw_hold = 1;
        check("hold_no_req", {31'b0, imem_req}, 32'd0);
        check("hold_ins_f", ins_f, NOP);
        check("hold_d_pc", pc_d, 32'h4);
      end
    end
    check("stall_reached", {31'b0, saw_hold}, 32'd1);
    check("req_count", req_addr_log.size(), 32'd7);
    if (req_addr_log.size() >= 7) begin
      for (int i = 0; i < 7; i++) check($sformatf("req_addr_%0d", i), req_addr_log[i], exp_addrs[i]);
      check("req_gap_0_1", req_cyc_log[1] - req_cyc_log[0], 32'd2);
      check("req_gap_1_2", req_cyc_log[2] - req_cyc_log[1], 32'd2);
      check("req_gap_stall", req_cyc_log[3] - req_cyc_log[2], 32'd4);
      check("first_d_latency", first_d_cyc - req_cyc_log[0], 32'd2);
    end

    // Flush while a slow request is outstanding.
    lat_lo = 3; lat_hi = 3;
    guard = 0;
    while (!(mem_pending && mem_delay >= 2) && guard < 40) begin step(0, 0, 32'h0); guard++; end
    check("flush_setup_bound", {31'b0, mem_pending}, 32'd1);
    n0 = req_addr_log.size();
    step(0, 1, 32'h40);
    lat_lo = 0; lat_hi = 0;
    guard = 0;
    while (req_addr_log.size() == n0 && guard < 20) begin
      step(0, 0, 32'h0);
      guard++;
      check("no_d_after_flush", {31'b0, valid_d}, 32'd0);
    end
    check("flush_redirect_seen", req_addr_log.size(), n0 + 1);
    if (req_addr_log.size() > n0) begin
      check("flush_redirect_addr", req_addr_log[n0], 32'h40);
      check("flush_redirect_timing", req_cyc_log[n0] - last_rvalid_cyc, 32'd1);
    end

    // Flush while decode is stalled on a live instruction.
    found = 0; guard = 0;
    while (!found && guard < 30) begin
      neg();
      guard++;
      if (valid_d) begin
        apply(1, 1, 32'h80);
        found = 1;
      end else begin
        apply(0, 0, 32'h0);
      end
    end
    check("flush_stall_setup", {31'b0, found}, 32'd1);
    neg();
    check("flush_stall_valid", {31'b0, valid_d}, 32'd0);
    check("flush_stall_pc_f", pc_f, 32'h80);
    apply(0, 0, 32'h0);
    repeat (12) step(0, 0, 32'h0);

    // PC wrap at the top of the address space.
    step(0, 1, 32'hFFFF_FFFC);
    found = 0; guard = 0;
    while (!found && guard < 30) begin
      step(0, 0, 32'h0);
      guard++;
      if (valid_d && pc_d == 32'hFFFF_FFFC) begin
        found = 1;
        check("wrap_pcplus4", pcplus4_d, 32'h0);
      end
    end
    check("wrap_seen", {31'b0, found}, 32'd1);
    repeat (6) step(0, 0, 32'h0);

    // Reset in WAIT, then a stray rvalid while IDLE must be ignored.
    lat_lo = 3; lat_hi = 3;
    guard = 0;
    while (!(mem_pending && mem_delay >= 1) && guard < 40) begin step(0, 0, 32'h0); guard++; end
    check("reset_wait_setup", {31'b0, mem_pending}, 32'd1);
    lat_lo = 0; lat_hi = 0;
    do_reset(1, 1);
    step(0, 0, 32'h0);
    check("post_reset_req", {31'b0, imem_req}, 32'd1);
    check("post_reset_addr", imem_addr, RESET_PC);
    repeat (20) step(0, 0, 32'h0);

    // Randomized traffic: variable latency, backpressure, stalls and flushes.
    lat_lo = 0; lat_hi = 3; ready_pct = 70;
    l0 = loads;
    for (int i = 0; i < 1500; i++) begin
      bit st, fl;
      st  = ($urandom_range(0, 99) < 30);
      fl  = ($urandom_range(0, 99) < 3);
      tgt = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0;
      step(st, fl, tgt);
    end
    check("random_progress", {31'b0, (loads - l0) > 100}, 32'd1);
    step(0, 0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
